// File: rtl/dm_ahb_slave.sv
// AHB-Lite slave bridging single transfers onto a synchronous data SRAM.
// Pipelined: a new address phase is taken whenever the current data phase completes.
//
// state     | meaning
// IDLE      | no transfer in progress, ready for address phase
// WRITE     | single-cycle SRAM write of the latched transfer
// RD_WAIT   | SRAM read issued, bus held with HReady_out low
// RD_DATA   | SRAM read data returned on HRead_data
// ERR1      | first ERROR cycle, bus held
// ERR2      | second ERROR cycle, bus released
module dm_ahb_slave #(
  parameter int MEM_WORDS = 16384,
  parameter int AW        = 14
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          HSel,
  input  logic [31:0]   HAddress,
  input  logic [1:0]    HTrans,
  input  logic [2:0]    HSize,
  input  logic          HWrite,
  input  logic [31:0]   HWrite_data,
  input  logic          HReady,
  output logic          HReady_out,
  output logic [1:0]    HResp,
  output logic [31:0]   HRead_data,
  output logic          DM_cs,
  output logic          DM_oe,
  output logic [3:0]    DM_we,
  output logic [AW-1:0] DM_addr,
  output logic [31:0]   DM_wdata,
  input  logic [31:0]   DM_rdata
);

  typedef enum logic [2:0] {
    S_IDLE, S_WRITE, S_RD_WAIT, S_RD_DATA, S_ERR1, S_ERR2
  } state_t;

  state_t        r_state, w_next;
  logic [AW+1:0] r_addr;
  logic [1:0]    r_size;
  logic          r_write;

  logic          w_can_accept, w_active, w_accept, w_oob, w_illegal;
  logic [3:0]    w_we;

  assign w_can_accept = (r_state == S_IDLE) || (r_state == S_WRITE) ||
                        (r_state == S_RD_DATA) || (r_state == S_ERR2);
  assign w_active     = (HTrans == 2'b10) || (HTrans == 2'b11);
  assign w_accept     = w_can_accept && HSel && HReady && w_active;

  // Anything past the last SRAM word is rejected rather than aliased.
  assign w_oob     = (HAddress[31:2] >= 30'(MEM_WORDS));
  assign w_illegal = HSize[2] || (HSize[1:0] == 2'b11) ||
                     ((HSize[1:0] == 2'b01) && HAddress[0]) ||
                     ((HSize[1:0] == 2'b10) && (HAddress[1:0] != 2'b00)) ||
                     w_oob;

  always_comb begin
    w_we = 4'b1111;
    case (r_size)
      2'b00:   w_we = 4'b0001 << r_addr[1:0];
      2'b01:   w_we = r_addr[1] ? 4'b1100 : 4'b0011;
      default: w_we = 4'b1111;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_addr  <= '0;
      r_size  <= 2'b00;
      r_write <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_addr  <= HAddress[AW+1:0];
        r_size  <= HSize[1:0];
        r_write <= HWrite;
      end
    end
  end

  always_comb begin
    w_next     = S_IDLE;
    HReady_out = 1'b1;
    HResp      = 2'b00;
    HRead_data = 32'h0;
    DM_cs      = 1'b0;
    DM_oe      = 1'b0;
    DM_we      = 4'b0000;
    DM_addr    = '0;
    DM_wdata   = 32'h0;

    case (r_state)
      S_WRITE: begin
        DM_cs    = 1'b1;
        DM_we    = w_we;
        DM_addr  = r_addr[AW+1:2];
        DM_wdata = HWrite_data;
      end
      S_RD_WAIT: begin
        DM_cs      = 1'b1;
        DM_oe      = ~r_write;
        DM_addr    = r_addr[AW+1:2];
        HReady_out = 1'b0;
      end
      S_RD_DATA: HRead_data = DM_rdata;
      S_ERR1: begin
        HResp      = 2'b01;
        HReady_out = 1'b0;
      end
      S_ERR2:  HResp = 2'b01;
      default: ;
    endcase

    if (r_state == S_RD_WAIT)
      w_next = S_RD_DATA;
    else if (r_state == S_ERR1)
      w_next = S_ERR2;
    else if (w_accept)
      w_next = w_illegal ? S_ERR1 : (HWrite ? S_WRITE : S_RD_WAIT);
  end

endmodule
